// File: rtl/ifm_feeder_if.sv
// SRAM read port and IFM buffer load port of the IFM feeder.
// master = feeder side, slave = SRAM/IFM-buffer side.
interface ifm_feeder_if #(
  parameter int INPUT_WIDTH   = 32,
  parameter int ADDR_WIDTH    = 12,
  parameter int INPUT_IFM_REG = 3
);
  logic                   mem_rd_en;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [INPUT_WIDTH-1:0] mem_rdata;
  logic [INPUT_WIDTH-1:0] ifm_input [INPUT_IFM_REG];
  logic [2:0]             ifm_read;
  logic [1:0]             mode;

  modport master (
    output mem_rd_en, mem_addr, ifm_input, ifm_read, mode,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd_en, mem_addr, ifm_input, ifm_read, mode,
    output mem_rdata
  );
endinterface

// File: rtl/ifm_feeder.sv
// Walks a packed IFM image strip by strip and feeds 3-row windows into the IFM buffer.
// Define IFM_FEEDER_ZPAD_EN to add a virtual zero row above and below every strip.
module ifm_feeder #(
  parameter int INPUT_WIDTH   = 32,
  parameter int INPUT_IFM_REG = 3,
  parameter int ADDR_WIDTH    = 12,
  parameter int DIM_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [DIM_WIDTH-1:0]  cfg_rows,
  input  logic [DIM_WIDTH-1:0]  cfg_strips,
  input  logic [1:0]            cfg_mode,
  input  logic                  stall,
  ifm_feeder_if.master          bus,
  output logic                  busy,
  output logic                  done
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int NW = DIM_WIDTH + 1;

`ifdef IFM_FEEDER_ZPAD_EN
  localparam logic ZPAD     = 1'b1;
  localparam int   MIN_ROWS = 1;
`else
  localparam logic ZPAD     = 1'b0;
  localparam int   MIN_ROWS = 3;
`endif

  logic [1:0]             state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [NW-1:0]          nrows_q, nrows_d;
  logic [DIM_WIDTH-1:0]   strips_q, strips_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  strip_addr_q, strip_addr_d;
  logic [NW-1:0]          ir_q, ir_d;
  logic [DIM_WIDTH-1:0]   is_q, is_d;
  logic [NW-1:0]          pr_q, pr_d;
  logic [DIM_WIDTH-1:0]   ps_q, ps_d;
  logic [1:0]             slot_q, slot_d;
  logic [1:0]             fcnt_q, fcnt_d;
  logic                   infl_q, infl_d;
  logic                   infl_zero_q, infl_zero_d;
  logic                   fin_q, fin_d;
  logic [2:0]             rd_q, rd_d;
  logic [INPUT_WIDTH-1:0] fifo_q [3];
  logic [INPUT_WIDTH-1:0] fifo_d [3];
  logic [INPUT_WIDTH-1:0] ifm_q  [3];
  logic [INPUT_WIDTH-1:0] ifm_d  [3];
  logic [INPUT_WIDTH-1:0] comb   [3];

  logic [2:0]             occ;
  logic [1:0]             popn;
  logic                   issue, virt, last_issue, active, prime, strm, row_end, last_pop;
  logic [INPUT_WIDTH-1:0] arr_data;

  // occ counts buffered rows plus the row whose SRAM data lands this cycle
  assign occ        = {1'b0, fcnt_q} + {2'b00, infl_q};
  assign issue      = (state_q == S_RUN) && !stall && (occ < 3'd3);
  assign virt       = ZPAD && ((ir_q == '0) || (ir_q == nrows_q - NW'(1)));
  assign last_issue = (ir_q == nrows_q - NW'(1)) && (is_q == strips_q - DIM_WIDTH'(1));
  assign arr_data   = infl_zero_q ? '0 : bus.mem_rdata;

  // Arriving data is visible in the same cycle so a row can be presented 2 cycles after its read
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_view
      assign comb[gi]          = (2'(gi) < fcnt_q) ? fifo_q[gi] : arr_data;
      assign bus.ifm_input[gi] = ifm_q[gi];
    end
  endgenerate

  assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign prime    = active && !stall && (pr_q == '0) && (occ == 3'd3);
  assign strm     = active && !stall && (pr_q != '0) && (occ != 3'd0);
  assign row_end  = prime ? (nrows_q == NW'(3)) : (pr_q == nrows_q - NW'(1));
  assign last_pop = (prime || strm) && row_end && (ps_q == strips_q - DIM_WIDTH'(1));
  assign popn     = prime ? 2'd3 : (strm ? 2'd1 : 2'd0);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    nrows_d      = nrows_q;
    strips_d     = strips_q;
    addr_d       = addr_q;
    strip_addr_d = strip_addr_q;
    ir_d         = ir_q;
    is_d         = is_q;
    pr_d         = pr_q;
    ps_d         = ps_q;
    slot_d       = slot_q;
    fin_d        = fin_q || last_pop;
    rd_d         = 3'b000;
    ifm_d        = ifm_q;
    infl_d       = issue;
    infl_zero_d  = issue && virt;
    fcnt_d       = 2'(occ - {1'b0, popn});
    for (int k = 0; k < 3; k++) fifo_d[k] = comb[k];
    if (popn == 2'd1) begin
      fifo_d[0] = comb[1];
      fifo_d[1] = comb[2];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d       = cfg_mode;
          nrows_d      = NW'(cfg_rows) + (ZPAD ? NW'(2) : NW'(0));
          strips_d     = cfg_strips;
          addr_d       = cfg_base_addr;
          strip_addr_d = cfg_base_addr;
          ir_d         = '0;
          is_d         = '0;
          pr_d         = '0;
          ps_d         = '0;
          slot_d       = 2'd0;
          fin_d        = 1'b0;
          if ((cfg_rows < DIM_WIDTH'(MIN_ROWS)) || (cfg_strips == '0)) state_d = S_DONE;
          else                                                         state_d = S_RUN;
        end
      end
      S_RUN:   if (issue && last_issue) state_d = S_DRAIN;
      S_DRAIN: if (fin_q) state_d = S_DONE;
      default: begin
        state_d = S_IDLE;
        mode_d  = 2'b00;
      end
    endcase

    if (issue) begin
      if (!virt) addr_d = addr_q + ADDR_WIDTH'(strips_q);
      if (ir_q == nrows_q - NW'(1)) begin
        ir_d         = '0;
        is_d         = is_q + DIM_WIDTH'(1);
        strip_addr_d = strip_addr_q + ADDR_WIDTH'(1);
        addr_d       = strip_addr_q + ADDR_WIDTH'(1);
      end else begin
        ir_d = ir_q + NW'(1);
      end
    end

    if (prime) begin
      for (int k = 0; k < 3; k++) ifm_d[k] = comb[k];
      rd_d   = 3'b111;
      slot_d = 2'd0;
      pr_d   = row_end ? '0 : NW'(3);
      if (row_end) ps_d = ps_q + DIM_WIDTH'(1);
    end else if (strm) begin
      for (int k = 0; k < 3; k++) if (slot_q == 2'(k)) ifm_d[k] = comb[0];
      rd_d   = 3'b001 << slot_q;
      slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
      if (row_end) begin
        pr_d   = '0;
        ps_d   = ps_q + DIM_WIDTH'(1);
        slot_d = 2'd0;
      end else begin
        pr_d = pr_q + NW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 2'b00;
      nrows_q      <= '0;
      strips_q     <= '0;
      addr_q       <= '0;
      strip_addr_q <= '0;
      ir_q         <= '0;
      is_q         <= '0;
      pr_q         <= '0;
      ps_q         <= '0;
      slot_q       <= 2'd0;
      fcnt_q       <= 2'd0;
      infl_q       <= 1'b0;
      infl_zero_q  <= 1'b0;
      fin_q        <= 1'b0;
      rd_q         <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        fifo_q[k] <= '0;
        ifm_q[k]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      nrows_q      <= nrows_d;
      strips_q     <= strips_d;
      addr_q       <= addr_d;
      strip_addr_q <= strip_addr_d;
      ir_q         <= ir_d;
      is_q         <= is_d;
      pr_q         <= pr_d;
      ps_q         <= ps_d;
      slot_q       <= slot_d;
      fcnt_q       <= fcnt_d;
      infl_q       <= infl_d;
      infl_zero_q  <= infl_zero_d;
      fin_q        <= fin_d;
      rd_q         <= rd_d;
      for (int k = 0; k < 3; k++) begin
        fifo_q[k] <= fifo_d[k];
        ifm_q[k]  <= ifm_d[k];
      end
    end
  end

  assign bus.mem_rd_en = issue && !virt;
  assign bus.mem_addr  = addr_q;
  assign bus.ifm_read  = rd_q;
  assign bus.mode      = mode_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_ifm_feeder.sv
// Directed and randomized jobs for ifm_feeder checked against a row-list reference model.
// Build with +define+IFM_FEEDER_ZPAD_EN to exercise the zero-padding variant.
module tb_ifm_feeder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [11:0] cfg_base_addr = '0;
  logic [7:0]  cfg_rows = '0;
  logic [7:0]  cfg_strips = '0;
  logic [1:0]  cfg_mode = '0;
  logic        stall = 1'b0;
  logic        busy, done;

  ifm_feeder_if #(.INPUT_WIDTH(32), .ADDR_WIDTH(12), .INPUT_IFM_REG(3)) bus ();

  ifm_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_base_addr(cfg_base_addr),
    .cfg_rows(cfg_rows), .cfg_strips(cfg_strips), .cfg_mode(cfg_mode),
    .stall(stall), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [4096];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

`ifdef IFM_FEEDER_ZPAD_EN
  localparam int MIN_ROWS = 1;
`else
  localparam int MIN_ROWS = 3;
`endif

  typedef struct packed { logic [2:0] rd; logic [31:0] s0, s1, s2; } pres_t;
  pres_t       exp_pres [$];
  logic [11:0] exp_addr [$];
  logic [31:0] mslot [3];
  int          n_checks = 0;
  int          n_pass = 0;
  string       cur_job = "init";

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s/%s got=%0h exp=%0h", cur_job, tag, got, exp);
  endtask

  // Expected behaviour: each strip is a list of rows; the first three form the prime window,
  // every later row j overwrites slot j%3.
  task automatic build_model(input int base, input int rows, input int strips);
    logic [31:0] row_val [$];
    pres_t p;
    int a;
    exp_pres.delete();
    exp_addr.delete();
    if (rows < MIN_ROWS || strips == 0) return;
    for (int s = 0; s < strips; s++) begin
      row_val.delete();
`ifdef IFM_FEEDER_ZPAD_EN
      row_val.push_back(32'h0);
`endif
      for (int r = 0; r < rows; r++) begin
        a = (base + r * strips + s) % 4096;
        exp_addr.push_back(a[11:0]);
        row_val.push_back(mem[a]);
      end
`ifdef IFM_FEEDER_ZPAD_EN
      row_val.push_back(32'h0);
`endif
      for (int j = 0; j < row_val.size(); j++) begin
        mslot[j % 3] = row_val[j];
        if (j >= 2) begin
          p.rd = (j == 2) ? 3'b111 : (3'b001 << (j % 3));
          p.s0 = mslot[0];
          p.s1 = mslot[1];
          p.s2 = mslot[2];
          exp_pres.push_back(p);
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    cur_job = tag;
    check("rd_en", bus.mem_rd_en, 0);
    check("ifm_read", bus.ifm_read, 0);
    check("slot0", bus.ifm_input[0], 0);
    check("slot1", bus.ifm_input[1], 0);
    check("slot2", bus.ifm_input[2], 0);
    check("mode", bus.mode, 0);
    check("busy", busy, 0);
    check("done", done, 0);
  endtask

  // plan: 0 no stall, 1 random stall, 2 five-cycle stall after the first 001
  task automatic run_job(input string name, input int base, input int rows, input int strips,
                         input logic [1:0] md, input int plan);
    int    cyc, last_pres, n_reads, model_reads, stall_cnt;
    bit    seen_done, prev_stall, stalled_once;
    pres_t p;
    cur_job = name;
    build_model(base, rows, strips);
    model_reads = exp_addr.size();
    n_reads = 0; last_pres = 0; stall_cnt = 0;
    seen_done = 0; prev_stall = 0; stalled_once = 0;
    @(posedge clk); #1;
    cfg_base_addr = base[11:0];
    cfg_rows = rows[7:0];
    cfg_strips = strips[7:0];
    cfg_mode = md;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!seen_done && cyc <= 3000) begin
      if (prev_stall) check("read_in_stall", bus.ifm_read, 0);
      if (bus.ifm_read != 3'b000) begin
        if (exp_pres.size() == 0) begin
          check("extra_pres", bus.ifm_read, 0);
        end else begin
          p = exp_pres.pop_front();
          check("rd", bus.ifm_read, p.rd);
          check("s0", bus.ifm_input[0], p.s0);
          check("s1", bus.ifm_input[1], p.s1);
          check("s2", bus.ifm_input[2], p.s2);
          $display("%s t=%0d rd=%b slots=%h %h %h", name, cyc, bus.ifm_read,
                   bus.ifm_input[0], bus.ifm_input[1], bus.ifm_input[2]);
        end
        last_pres = cyc;
      end
      check("busy", busy, 1);
      check("mode", bus.mode, md);
      if (done) begin
        seen_done = 1;
        check("pres_left", exp_pres.size(), 0);
        check("done_time", cyc, last_pres + 1);
        check("nreads", n_reads, model_reads);
      end else begin
        if (plan == 1) stall = ($urandom_range(0, 3) == 0);
        if (plan == 2) begin
          if (!stalled_once && bus.ifm_read == 3'b001) begin
            stall_cnt = 5;
            stalled_once = 1;
          end
          stall = (stall_cnt > 0);
          if (stall_cnt > 0) stall_cnt--;
        end
        #1;
        if (stall) check("rd_en_stall", bus.mem_rd_en, 0);
        if (bus.mem_rd_en) begin
          n_reads++;
          if (exp_addr.size() != 0) check("addr", bus.mem_addr, exp_addr.pop_front());
        end
        prev_stall = stall;
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("finished", seen_done, 1);
    stall = 1'b0;
    @(posedge clk); #1;
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    check("mode_after", bus.mode, 0);
    $display("job %s base=%h H=%0d S=%0d reads=%0d cycles=%0d", name, base, rows, strips, n_reads, cyc);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {8'h00, 24'($urandom)};
    for (int i = 0; i < 3; i++) mslot[i] = 32'h0;
    mem[0] = 32'h00010203; mem[1] = 32'h00040506;
    mem[2] = 32'h00070809; mem[3] = 32'h000A0B0C;

    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("post_reset");

    run_job("basic", 0, 4, 1, 2'b01, 0);
    run_job("rotation", 12'h100, 7, 1, 2'b10, 0);
    run_job("multistrip", 12'h010, 3, 2, 2'b11, 0);
    run_job("stall", 12'h200, 6, 1, 2'b01, 2);
    run_job("degenerate", 12'h300, MIN_ROWS - 1, 1, 2'b10, 0);
    run_job("zero_strips", 12'h300, 5, 0, 2'b01, 0);
    run_job("zpad_h2", 12'h040, 2, 1, 2'b01, 0);
    run_job("addr_wrap", 12'hFFE, 4, 2, 2'b11, 1);

    // Abort a job mid-strip, then replay it from strip 0
    cur_job = "abort";
    @(posedge clk); #1;
    cfg_base_addr = 12'h020; cfg_rows = 8'd7; cfg_strips = 8'd2; cfg_mode = 2'b10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("reset_mid");
    for (int i = 0; i < 3; i++) mslot[i] = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_job("replay", 12'h020, 7, 2, 2'b10, 0);

    for (int n = 0; n < 8; n++) begin
      run_job("random", int'($urandom_range(0, 4095)), int'($urandom_range(1, 9)),
              int'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
